// File: rtl/user_wr_axi_master.sv
// rtl/user_wr_axi_master.sv - buffers user write commands/data and issues AXI4 INCR write bursts
// Commands are split on MAX_BURST and 4 KB boundaries; B responses drive done/error reporting.

module user_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign dout_o  = mem_q[rd_ptr_q];
  // A push at full is accepted only when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign ovf_o   = push_i && full_o && !pop_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module user_wr_axi_master #(
  parameter int MAX_BURST  = 256,
  parameter int DATA_DEPTH = 1024,
  parameter int CMD_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [44:0] user_wr_cmd,
  input  logic        user_cmd_wen,
  input  logic [63:0] user_wr_data,
  input  logic        user_wr_en,
  output logic        cmd_full,
  output logic        data_full,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_AW, S_W, S_B} state_t;

  localparam logic [12:0] MAXB = 13'(MAX_BURST);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [12:0] rem_q, rem_d;
  logic [8:0]  blen_q, blen_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [7:0]  awlen_q, awlen_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [44:0] cmd_head;
  logic        cmd_empty, cmd_pop, cmd_ovf;
  logic [63:0] data_head;
  logic        data_empty, data_pop, data_ovf;
  logic [12:0] room, blen_c;
  logic        last_beat;

  user_wr_fifo #(.W(45), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i(clk), .rst_i(rst), .push_i(user_cmd_wen), .din_i(user_wr_cmd),
    .pop_i(cmd_pop), .dout_o(cmd_head), .empty_o(cmd_empty), .full_o(cmd_full),
    .ovf_o(cmd_ovf)
  );

  user_wr_fifo #(.W(64), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk_i(clk), .rst_i(rst), .push_i(user_wr_en), .din_i(user_wr_data),
    .pop_i(data_pop), .dout_o(data_head), .empty_o(data_empty), .full_o(data_full),
    .ovf_o(data_ovf)
  );

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wdata   = (state_q == S_W) ? data_head : 64'd0;
  assign wr_busy       = (state_q != S_IDLE);
  assign wr_done       = done_q;
  assign wr_err        = err_q;

  // Beats left before the next 4 KB page boundary (addr is 8-byte aligned).
  always_comb begin
    room   = (13'd4096 - {1'b0, addr_q[11:0]}) >> 3;
    blen_c = rem_q;
    if (blen_c > MAXB) blen_c = MAXB;
    if (blen_c > room) blen_c = room;
  end

  assign last_beat = ({1'b0, beat_q} == (blen_q - 9'd1));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    blen_d        = blen_q;
    beat_d        = beat_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    done_d        = 1'b0;
    err_d         = err_q | cmd_ovf | data_ovf;
    cmd_pop       = 1'b0;
    data_pop      = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          if (cmd_head[44:32] != 13'd0) begin
            addr_d  = cmd_head[31:0] & 32'hFFFF_FFF8;
            rem_d   = cmd_head[44:32];
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        blen_d   = 9'(blen_c);
        awaddr_d = addr_q;
        awlen_d  = 8'(blen_c - 13'd1);
        beat_d   = 8'd0;
        state_d  = S_AW;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = !data_empty;
        m_axi_wlast  = last_beat;
        if (m_axi_wvalid && m_axi_wready) begin
          data_pop = 1'b1;
          beat_d   = beat_q + 8'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          addr_d = addr_q + {20'd0, blen_q, 3'b000};
          rem_d  = rem_q - {4'd0, blen_q};
          if (rem_q == {4'd0, blen_q}) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_user_wr_axi_master.sv
// tb/tb_user_wr_axi_master.sv - directed bench for user_wr_axi_master
// A responsive AXI slave logs AW/W/B traffic; logs are compared against hand-computed bursts.

module tb_user_wr_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [44:0] user_wr_cmd;
  logic        user_cmd_wen;
  logic [63:0] user_wr_data;
  logic        user_wr_en;
  logic        cmd_full, data_full;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        wr_busy, wr_done, wr_err;

  always #5 clk = ~clk;

  user_wr_axi_master dut (
    .clk(clk), .rst(rst),
    .user_wr_cmd(user_wr_cmd), .user_cmd_wen(user_cmd_wen),
    .user_wr_data(user_wr_data), .user_wr_en(user_wr_en),
    .cmd_full(cmd_full), .data_full(data_full),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int stall_en = 0, w_hold = 0, err_burst = -1;
  int b_cnt = 0, b_pend = 0, done_cnt = 0, viol = 0;
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [63:0] w_data_log[$];
  logic        w_last_log[$];
  logic [31:0] ex_addr[$];
  int          ex_len[$];

  logic        aw_st = 1'b0, w_st = 1'b0;
  logic [31:0] aw_st_addr;
  logic [7:0]  aw_st_len;
  logic [63:0] w_st_data;
  logic        w_st_last;

  // Slave: drive readies at negedge, sample the handshakes that the next posedge will take.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      m_axi_awready = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = w_hold != 0 ? 1'b0 : (stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bvalid  = (b_pend > 0) && (stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (rst) begin
        b_pend = 0; aw_st = 1'b0; w_st = 1'b0;
      end else begin
        if (aw_st && !(m_axi_awvalid && m_axi_awaddr == aw_st_addr && m_axi_awlen == aw_st_len)) viol++;
        if (w_st && !(m_axi_wvalid && m_axi_wdata == w_st_data && m_axi_wlast == w_st_last)) viol++;
        aw_st = m_axi_awvalid && !m_axi_awready;
        aw_st_addr = m_axi_awaddr; aw_st_len = m_axi_awlen;
        w_st = m_axi_wvalid && !m_axi_wready;
        w_st_data = m_axi_wdata; w_st_last = m_axi_wlast;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_addr_log.push_back(m_axi_awaddr); aw_len_log.push_back(m_axi_awlen);
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_data_log.push_back(m_axi_wdata); w_last_log.push_back(m_axi_wlast);
          if (m_axi_wlast) b_pend++;
        end
        if (m_axi_bvalid && m_axi_bready) begin b_pend--; b_cnt++; end
        if (wr_done) done_cnt++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
    done_cnt = 0; b_cnt = 0; viol = 0;
  endtask

  task automatic push_cmd(input logic [12:0] cnt, input logic [31:0] addr);
    @(negedge clk);
    user_wr_cmd = {cnt, addr}; user_cmd_wen = 1'b1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    user_cmd_wen = 1'b0; user_wr_en = 1'b0;
  endtask

  task automatic push_data(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      user_wr_data = base + 64'(i); user_wr_en = 1'b1;
    end
    idle_in();
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 20000 && done_cnt < target; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_logs(input string tag, input logic [63:0] base);
    int idx = 0;
    int mism = 0;
    chk({tag, "_naw"}, 64'(aw_addr_log.size()), 64'(ex_addr.size()));
    foreach (ex_addr[b]) begin
      if (b < aw_addr_log.size()) begin
        chk($sformatf("%s_awaddr%0d", tag, b), 64'(aw_addr_log[b]), 64'(ex_addr[b]));
        chk($sformatf("%s_awlen%0d", tag, b), 64'(aw_len_log[b]), 64'(ex_len[b]));
      end
      for (int j = 0; j <= ex_len[b]; j++) begin
        if (idx >= w_data_log.size() || w_data_log[idx] !== base + 64'(idx) ||
            w_last_log[idx] !== (j == ex_len[b])) mism++;
        idx++;
      end
    end
    chk({tag, "_nbeats"}, 64'(w_data_log.size()), 64'(idx));
    chk({tag, "_wbeats"}, 64'(mism), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    chk({tag, "_wvalid"},  64'(m_axi_wvalid),  64'd0);
    chk({tag, "_wlast"},   64'(m_axi_wlast),   64'd0);
    chk({tag, "_bready"},  64'(m_axi_bready),  64'd0);
    chk({tag, "_busy"},    64'(wr_busy),       64'd0);
    chk({tag, "_done"},    64'(wr_done),       64'd0);
    chk({tag, "_err"},     64'(wr_err),        64'd0);
    chk({tag, "_awaddr"},  64'(m_axi_awaddr),  64'd0);
    chk({tag, "_awlen"},   64'(m_axi_awlen),   64'd0);
    chk({tag, "_wdata"},   m_axi_wdata,        64'd0);
    chk({tag, "_dfull"},   64'(data_full),     64'd0);
    chk({tag, "_cfull"},   64'(cmd_full),      64'd0);
  endtask

  initial begin
    rst = 1'b1; user_wr_cmd = '0; user_cmd_wen = 1'b0; user_wr_data = '0; user_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    chk("awsize", 64'(m_axi_awsize), 64'd3);
    chk("awburst", 64'(m_axi_awburst), 64'd1);
    chk("wstrb", 64'(m_axi_wstrb), 64'hFF);
    rst = 1'b0;

    // T1: 1024 beats from address 0 -> four full 256-beat bursts
    clear_logs();
    ex_addr = '{32'h0, 32'h800, 32'h1000, 32'h1800}; ex_len = '{255, 255, 255, 255};
    push_data(1024, 64'h1000_0000_0000_0000);
    chk("t1_dfull", 64'(data_full), 64'd1);
    push_cmd(13'd1024, 32'h0); idle_in();
    wait_done("t1", 1);
    check_logs("t1", 64'h1000_0000_0000_0000);

    // T2: 10 beats at 0x0FF0 -> split at the 4 KB page
    clear_logs();
    ex_addr = '{32'h0FF0, 32'h1000}; ex_len = '{1, 7};
    push_data(10, 64'hBEEF_0000_0000_0000);
    push_cmd(13'd10, 32'h0FF0); idle_in();
    wait_done("t2", 1);
    check_logs("t2", 64'hBEEF_0000_0000_0000);

    // T3: T1 with random ready/valid stalls from the slave
    clear_logs();
    stall_en = 1;
    ex_addr = '{32'h0, 32'h800, 32'h1000, 32'h1800}; ex_len = '{255, 255, 255, 255};
    push_data(1024, 64'h3300_0000_0000_0000);
    push_cmd(13'd1024, 32'h0); idle_in();
    wait_done("t3", 1);
    check_logs("t3", 64'h3300_0000_0000_0000);
    chk("t3_stable", 64'(viol), 64'd0);
    stall_en = 0;

    // T4: SLVERR on the second burst
    clear_logs();
    chk("t4_err_pre", 64'(wr_err), 64'd0);
    err_burst = 1;
    push_data(1024, 64'h4400_0000_0000_0000);
    push_cmd(13'd1024, 32'h0); idle_in();
    wait_done("t4", 1);
    check_logs("t4", 64'h4400_0000_0000_0000);
    chk("t4_err", 64'(wr_err), 64'd1);
    err_burst = -1;

    // T5: two back-to-back commands, then a zero-length command
    clear_logs();
    ex_addr = '{32'h0, 32'h2000}; ex_len = '{3, 3};
    push_data(8, 64'h5500_0000_0000_0000);
    push_cmd(13'd4, 32'h0); push_cmd(13'd4, 32'h2000); idle_in();
    wait_done("t5", 2);
    check_logs("t5", 64'h5500_0000_0000_0000);
    clear_logs();
    push_cmd(13'd0, 32'h100); idle_in();
    repeat (20) @(negedge clk);
    chk("t5_zero_naw", 64'(aw_addr_log.size()), 64'd0);
    chk("t5_zero_done", 64'(done_cnt), 64'd0);
    chk("t5_zero_busy", 64'(wr_busy), 64'd0);
    chk("t5_err_sticky", 64'(wr_err), 64'd1);

    // T6: overflow the data FIFO while the slave withholds wready, then reset mid-W
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("t6_pre");
    clear_logs();
    w_hold = 1;
    push_cmd(13'd1024, 32'h0); idle_in();
    push_data(1024, 64'h6600_0000_0000_0000);
    chk("t6_dfull", 64'(data_full), 64'd1);
    chk("t6_err_full", 64'(wr_err), 64'd0);
    push_data(1, 64'h6600_0000_0000_0400);
    chk("t6_err_ovf", 64'(wr_err), 64'd1);
    chk("t6_wvalid", 64'(m_axi_wvalid), 64'd1);
    chk("t6_busy", 64'(wr_busy), 64'd1);
    chk("t6_wdata", m_axi_wdata, 64'h6600_0000_0000_0000);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6_rst");
    rst = 1'b0;
    w_hold = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
